// File: rtl/comm_timer.sv
// comm_timer: timeout generator that sits beside the communication FSM.
//
// Holds three independent down-counters:
//   idle  - runs while timer_idle is high, (re)loaded on its rising edge; its expiry
//           raises a sticky done flag and a single-cycle disconnect pulse.
//   gopds - loaded by a timer_gopds pulse; bounds the wait for all operands.
//   delay - loaded by a timer_delay pulse; models the memory-access delay before ACK.
// A load always wins over a simultaneous expiry, and counters never wrap below zero.
//
// Optional feature (macro COMM_TIMER_PRESCALER_EN): a free-running prescaler makes the
// counters decrement once every PRESCALE clocks instead of every clock. Loads still act
// on any clock. With the macro undefined the tick is tied high and no prescaler exists.
//
// Ports:
//   clk          in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   timer_idle   in   level, FSM idle; rising edge (re)loads the idle counter
//   timer_gopds  in   1-cycle pulse, loads the get-operands counter
//   timer_delay  in   1-cycle pulse, loads the delay counter
//   mux_timer    in   [2:0] time_out select: 000 idle, 001 gopds, 010 delay, else none
//   time_out     out  done flag of the selected counter
//   disconnect   out  registered 1-cycle pulse on idle-counter expiry
module comm_timer #(
    parameter int unsigned CNT_W        = 32,
    parameter int unsigned IDLE_CYCLES  = 50_000_000,
    parameter int unsigned GOPDS_CYCLES = 5_000_000,
    parameter int unsigned DELAY_CYCLES = 16,
    parameter int unsigned PRESCALE     = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       timer_idle,
    input  logic       timer_gopds,
    input  logic       timer_delay,
    input  logic [2:0] mux_timer,
    output logic       time_out,
    output logic       disconnect
);

    localparam logic [CNT_W-1:0] IdleLoad  = CNT_W'(IDLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] GopdsLoad = CNT_W'(GOPDS_CYCLES - 1);
    localparam logic [CNT_W-1:0] DelayLoad = CNT_W'(DELAY_CYCLES - 1);
    localparam logic [CNT_W-1:0] CntOne    = CNT_W'(1);

    // Elaboration-time sanity checks on the configuration.
    if (IDLE_CYCLES < 1 || GOPDS_CYCLES < 1 || DELAY_CYCLES < 1) begin : gen_bad_cycles
        $error("comm_timer: *_CYCLES must be at least 1");
    end
    if (PRESCALE < 1) begin : gen_bad_prescale
        $error("comm_timer: PRESCALE must be at least 1");
    end

    logic tick;

`ifdef COMM_TIMER_PRESCALER_EN
    localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PrescLast = PW'(PRESCALE - 1);

    logic [PW-1:0] presc_q;

    assign tick = (presc_q == PrescLast);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
        end else if (tick) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_q + PW'(1);
        end
    end
`else
    assign tick = 1'b1;
`endif

    // Get-operands counter
    logic [CNT_W-1:0] gopds_cnt_q;
    logic             gopds_run_q;
    logic             gopds_done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gopds_cnt_q  <= '0;
            gopds_run_q  <= 1'b0;
            gopds_done_q <= 1'b0;
        end else if (timer_gopds) begin
            gopds_cnt_q  <= GopdsLoad;
            gopds_run_q  <= 1'b1;
            gopds_done_q <= 1'b0;
        end else if (gopds_run_q && tick) begin
            if (gopds_cnt_q != '0) begin
                gopds_cnt_q <= gopds_cnt_q - CntOne;
            end else begin
                gopds_run_q  <= 1'b0;
                gopds_done_q <= 1'b1;
            end
        end
    end

    // Delay counter
    logic [CNT_W-1:0] delay_cnt_q;
    logic             delay_run_q;
    logic             delay_done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            delay_cnt_q  <= '0;
            delay_run_q  <= 1'b0;
            delay_done_q <= 1'b0;
        end else if (timer_delay) begin
            delay_cnt_q  <= DelayLoad;
            delay_run_q  <= 1'b1;
            delay_done_q <= 1'b0;
        end else if (delay_run_q && tick) begin
            if (delay_cnt_q != '0) begin
                delay_cnt_q <= delay_cnt_q - CntOne;
            end else begin
                delay_run_q  <= 1'b0;
                delay_done_q <= 1'b1;
            end
        end
    end

    // Idle counter: loads on the rising edge of timer_idle, freezes while it is low.
    logic [CNT_W-1:0] idle_cnt_q;
    logic             idle_run_q;
    logic             idle_done_q;
    logic             idle_prev_q;
    logic             disconnect_q;
    logic             idle_rise;

    assign idle_rise = timer_idle && !idle_prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt_q   <= '0;
            idle_run_q   <= 1'b0;
            idle_done_q  <= 1'b0;
            idle_prev_q  <= 1'b0;
            disconnect_q <= 1'b0;
        end else begin
            idle_prev_q  <= timer_idle;
            disconnect_q <= 1'b0;
            if (idle_rise) begin
                idle_cnt_q  <= IdleLoad;
                idle_run_q  <= 1'b1;
                idle_done_q <= 1'b0;
            end else if (idle_run_q && tick && timer_idle) begin
                if (idle_cnt_q != '0) begin
                    idle_cnt_q <= idle_cnt_q - CntOne;
                end else begin
                    // Clearing run here is what limits disconnect to a single pulse.
                    idle_run_q   <= 1'b0;
                    idle_done_q  <= 1'b1;
                    disconnect_q <= 1'b1;
                end
            end
        end
    end

    assign disconnect = disconnect_q;

    always_comb begin
        time_out = 1'b0;
        case (mux_timer)
            3'b000:  time_out = idle_done_q;
            3'b001:  time_out = gopds_done_q;
            3'b010:  time_out = delay_done_q;
            default: time_out = 1'b0;
        endcase
    end

endmodule
